// File: rtl/ps2_key_rx_if.sv
// PS/2 keyboard receiver pin and key-event bundle.
// slave = receiver side, master = board/adapter side.
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  ps2_key,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host receiver producing 11-bit toggle-format key events.
// Optional clock glitch filter: define PS2_GLITCH_FILTER_EN.
module ps2_key_rx #(
  parameter int unsigned TIMEOUT_CYC = 12000,
  parameter int unsigned FILT_LEN    = 8
) (
  input  logic         clk_sys,
  input  logic         reset,
  ps2_key_rx_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          r_clk_s1;
  logic          r_clk_s2;
  logic          r_dat_s1;
  logic          r_dat_s2;
  logic          r_clk_prev;
  logic          w_clk;
  logic          w_fall;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_ext;
  logic          r_brk;
  logic [10:0]   r_key;
  logic          r_err;
  logic          r_busy;
  logic [TW-1:0] r_to_cnt;
  logic          w_bad;

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("FILT_LEN must be at least 1");
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_s1   <= bus.ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_dat_s1   <= bus.ps2_data;
      r_dat_s2   <= r_dat_s1;
      r_clk_prev <= w_clk;
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILT_LEN + 1);

  logic          r_filt;
  logic [FW-1:0] r_filt_cnt;

  // output follows only after FILT_LEN agreeing samples
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 != r_filt) begin
      if (r_filt_cnt == FW'(FILT_LEN - 1)) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end else begin
      r_filt_cnt <= '0;
    end
  end

  assign w_clk = r_filt;
`else
  assign w_clk = r_clk_s2;
`endif

  assign w_fall = r_clk_prev & ~w_clk;
  assign w_bad  = ~(^{r_shift, r_par}) | ~r_dat_s2;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_key     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_err <= 1'b0;
      if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
        if (w_fall && !r_dat_s2) begin
          r_state   <= S_DATA;
          r_bit_cnt <= '0;
          r_busy    <= 1'b1;
        end
      end else if (w_fall) begin
        r_to_cnt <= '0;
        unique case (r_state)
          S_DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (w_bad) begin
              r_err <= 1'b1;
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end else if (r_shift == 8'hE0) begin
              r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
              r_brk <= 1'b1;
            end else begin
              r_key <= {~r_key[10], ~r_brk, r_ext, r_shift};
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_to_cnt == TO_LAST) begin
        // stalled frame: abandon it and any pending prefix
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_err     <= 1'b1;
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_ext     <= 1'b0;
        r_brk     <= 1'b0;
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign bus.ps2_key   = r_key;
  assign bus.frame_err = r_err;
  assign bus.busy      = r_busy;

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Receives the PS/2 keyboard serial stream (device-to-host) and encodes each completed scancode into the 11-bit toggle-format key event word consumed by the core's keyboard decoders.
- Word layout: bit 10 = event toggle, bit 9 = pressed, bit 8 = extended (E0 prefix), bits 7:0 = scancode.
- Sits between the board PS/2 pins (or a user-port adapter) and the game input logic, in the clk_sys domain.
- Gives cores a keyboard path that does not depend on the HPS.

Parameters:
- TIMEOUT_CYC, 12000, clk_sys cycles without a PS/2 clock falling edge before a partial frame is abandoned (1 ms at 12 MHz).
- FILT_LEN, 8, stable-sample count required by the optional clock glitch filter.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  PS/2 clock pin, asynchronous
- ps2_data  in  1  PS/2 data pin, asynchronous
- ps2_key  out  11  key event word; bit 10 toggles once per event
- frame_err  out  1  one-cycle pulse on parity error, stop error or timeout
- busy  out  1  high while a frame is in progress (start bit seen, not yet finished or aborted)

Behaviour:
- Input synchronisation: two-flop synchronisers on ps2_clk and ps2_data. A falling edge is the synchronised clock going 1→0 between consecutive cycles.
- Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1. Each bit is sampled on the falling edge.
- FSM states:
  - IDLE: a falling edge with data=0 goes to DATA, bit count=0. A falling edge with data=1 is ignored and stays in IDLE.
  - DATA: shift in 8 bits, then go to PARITY.
  - PARITY: sample the parity bit, go to STOP.
  - STOP: on the stop edge, validate the frame and return to IDLE.
- Validation: the frame is valid only if XOR(data, parity)=1 and stop=1. Otherwise pulse frame_err for one cycle, discard the byte, and clear both prefix flags.
- Valid byte handling:
  - 0xE0: set ext_flag. No event.
  - 0xF0: set brk_flag. No event.
  - Any other byte: on the cycle after the stop-bit edge is detected, ps2_key <= {~ps2_key[10], ~brk_flag, ext_flag, byte}, then clear both flags.
  - Latency: stop-bit edge detected at cycle N → ps2_key updated at N+1.
- Prefix sequences: E0 F0 xx gives an extended break. F0 E0 xx gives the same result, since both flags are independent.
- Timeout:
  - A counter is cleared on every falling edge and increments while busy.
  - When it reaches TIMEOUT_CYC: pulse frame_err, return to IDLE, clear partial data and both prefix flags.
  - The counter does not run in IDLE.
- busy: rises on the cycle after the start-bit edge; falls on the cycle the FSM re-enters IDLE.
- Reset: has priority over all events in the same cycle. State=IDLE, ps2_key=11'h000, frame_err=0, busy=0, flags cleared, counters zero, synchronisers set to 1.
- Reset mid-frame drops the partial frame silently, with no frame_err.
- Glitches: a spurious extra clock edge after the stop bit is treated as a new start only if data=0.
- Bit-count wrap: impossible. The count saturates at the frame end.

Optional Feature:
- Macro: PS2_GLITCH_FILTER_EN.
- Defined: the synchronised ps2_clk passes through a filter that changes its output only after FILT_LEN consecutive identical samples. Edges are detected on the filtered clock, which adds FILT_LEN cycles of latency. Data is sampled at the filtered edge using the synchronised data.
- Undefined: edges are detected directly on the two-flop synchronised clock, with no extra latency.

Test Plan:
- Valid make code: send 0x1C with odd parity=0 and stop=1, starting from ps2_key=000 → ps2_key becomes 11'h61C one cycle after the stop edge; frame_err stays 0; busy is low afterwards.
- Extended break: send E0, F0, 75 → a single event, ps2_key=11'h575 (toggle 1, pressed 0, ext 1). No event is produced on the E0 or F0 frames.
- Parity error: send 0x29 with a wrong parity bit after a pending F0 → one frame_err pulse; ps2_key unchanged. Then send 0x29 correctly → ps2_key[9]=1, confirming brk_flag was cleared.
- Timeout: send start plus 4 data bits, then hold the clock high for TIMEOUT_CYC cycles → frame_err pulses exactly once; busy drops. Then send a full 0x16 frame → decoded correctly as 11'h616 with toggle flipped.
- Reset mid-frame: assert reset after 6 bits → busy=0, ps2_key=000, no frame_err. Then send a full 0x5A frame → ps2_key=11'h65A.
- With PS2_GLITCH_FILTER_EN: inject 3-cycle low pulses on ps2_clk while idle, with data=0 → no busy, no event. A genuine frame still decodes, with FILT_LEN added latency.
